// File: rtl/da_pkg.sv
// Shared types and width helpers for the distributed-arithmetic MAC.
// Contents: FSM state enum, LUT entry width and output width functions.
package da_pkg;

  typedef enum logic [1:0] {StIdle, StBuild, StCalc, StDone} state_e;

  // A LUT entry holds the sum of up to grp weights.
  function automatic int lut_width(input int ww, input int grp);
    return ww + $clog2(grp);
  endfunction

  // Full dot-product width; the sum of n_taps ww*xw products cannot overflow it.
  function automatic int out_width(input int ww, input int xw, input int n_taps);
    return ww + xw + $clog2(n_taps);
  endfunction

endpackage

// File: rtl/da_lut_bank.sv
// Partial-sum LUT for one group of GRP taps (GRP >= 2).
// Entry e holds the sum of the group weights whose bit is set in e.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset (clears all entries)
//   build_en, build_idx  write entry build_idx with the sum derived from w_grp
//   w_grp                GRP signed weights, tap i = w_grp[i*WW +: WW]
//   rd_addr, rd_data     combinational read port (sign-extended entry)
module da_lut_bank
  import da_pkg::*;
#(
  parameter int GRP = 4,
  parameter int WW  = 16,
  localparam int LW = lut_width(WW, GRP)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              build_en,
  input  logic [GRP-1:0]    build_idx,
  input  logic [GRP*WW-1:0] w_grp,
  input  logic [GRP-1:0]    rd_addr,
  output logic [LW-1:0]     rd_data
);

  localparam int NE = 2 ** GRP;

  logic [LW-1:0] lut_q [NE];
  logic [LW-1:0] build_sum;

  always_comb begin
    build_sum = '0;
    for (int i = 0; i < GRP; i++) begin
      if (build_idx[i]) begin
        build_sum = build_sum + {{(LW - WW){w_grp[i*WW+WW-1]}}, w_grp[i*WW +: WW]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int e = 0; e < NE; e++) lut_q[e] <= '0;
    end else if (build_en) begin
      lut_q[build_idx] <= build_sum;
    end
  end

  assign rd_data = lut_q[rd_addr];

endmodule

// File: rtl/da_partitioned_mac.sv
// Bit-serial distributed-arithmetic dot product y = sum_k w[k]*x[k] (signed).
// Weights live in a register file; any accepted write marks the group LUTs
// stale, and the next vector rebuilds them (2^GRP cycles) before computing.
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   w_we, w_addr, w_data         weight write, honoured only while w_ready
//   w_ready, in_ready            high in idle
//   in_valid, x_flat             sample vector, tap k = x_flat[k*XW +: XW]
//   out_valid, out_ready, y      result handshake, y held until taken
//   busy                         engine not idle
module da_partitioned_mac
  import da_pkg::*;
#(
  parameter int N_TAPS = 8,
  parameter int GRP    = 4,
  parameter int XW     = 8,
  parameter int WW     = 16,
  localparam int OW    = out_width(WW, XW, N_TAPS),
  localparam int AW    = (N_TAPS > 1) ? $clog2(N_TAPS) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 w_we,
  input  logic [AW-1:0]        w_addr,
  input  logic [WW-1:0]        w_data,
  output logic                 w_ready,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N_TAPS*XW-1:0] x_flat,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OW-1:0]        y,
  output logic                 busy
);

  localparam int NG = N_TAPS / GRP;
  localparam int LW = lut_width(WW, GRP);
  localparam int BW = (XW > 1) ? $clog2(XW) : 1;

  state_e state_q, state_d;

  logic [WW-1:0]        w_q [N_TAPS];
  logic                 stale_q;
  logic [N_TAPS*XW-1:0] x_q;
  logic [GRP-1:0]       ecnt_q;
  logic [BW-1:0]        bcnt_q;
  logic signed [OW-1:0] acc_q, acc_d, lout;
  logic [OW-1:0]        y_q;
  logic                 out_valid_q;
  logic [LW-1:0]        lut_rd [NG];

  logic w_acc, in_acc, last_entry, last_bit;

  assign w_acc      = w_we & w_ready;
  assign in_acc     = in_valid & in_ready;
  assign last_entry = (ecnt_q == '1);
  assign last_bit   = (bcnt_q == '0);

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // FSM: next state; a write in the accept cycle lands first and forces a rebuild
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (in_acc) state_d = (stale_q || w_acc) ? StBuild : StCalc;
      StBuild: if (last_entry) state_d = StCalc;
      StCalc:  if (last_bit) state_d = StDone;
      StDone:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM: outputs
  always_comb begin
    w_ready  = (state_q == StIdle);
    in_ready = (state_q == StIdle);
    busy     = (state_q != StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_TAPS; k++) w_q[k] <= '0;
    end else if (w_acc) begin
      w_q[w_addr] <= w_data;
    end
  end

  for (genvar g = 0; g < NG; g++) begin : g_grp
    logic [GRP*WW-1:0] w_grp;
    logic [GRP-1:0]    rd_addr;
    for (genvar i = 0; i < GRP; i++) begin : g_tap
      logic [XW-1:0] tap;
      assign tap                 = x_q[(g*GRP+i)*XW +: XW];
      assign w_grp[i*WW +: WW]   = w_q[g*GRP+i];
      assign rd_addr[i]          = tap[bcnt_q];
    end
    da_lut_bank #(
      .GRP (GRP),
      .WW  (WW)
    ) u_lut (
      .clk       (clk),
      .rst_n     (rst_n),
      .build_en  (state_q == StBuild),
      .build_idx (ecnt_q),
      .w_grp     (w_grp),
      .rd_addr   (rd_addr),
      .rd_data   (lut_rd[g])
    );
  end

  // Group adder tree and MSB-first accumulation; the sign bit carries weight -2^(XW-1).
  always_comb begin
    lout = '0;
    for (int g = 0; g < NG; g++) begin
      lout = lout + {{(OW - LW){lut_rd[g][LW-1]}}, lut_rd[g]};
    end
    if (bcnt_q == BW'(XW - 1)) acc_d = -lout;
    else                       acc_d = (acc_q <<< 1) + lout;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stale_q     <= 1'b0;
      x_q         <= '0;
      ecnt_q      <= '0;
      bcnt_q      <= '0;
      acc_q       <= '0;
      y_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (w_acc) stale_q <= 1'b1;
      else if (state_q == StBuild && last_entry) stale_q <= 1'b0;
      if (in_acc) begin
        x_q    <= x_flat;
        ecnt_q <= '0;
        bcnt_q <= BW'(XW - 1);
      end
      if (state_q == StBuild) ecnt_q <= ecnt_q + 1'b1;
      if (state_q == StCalc) begin
        acc_q  <= acc_d;
        bcnt_q <= bcnt_q - 1'b1;
        if (last_bit) begin
          y_q         <= acc_d;
          out_valid_q <= 1'b1;
        end
      end
      if (state_q == StDone && out_ready) out_valid_q <= 1'b0;
    end
  end

  assign y         = y_q;
  assign out_valid = out_valid_q;

endmodule
